pbkdf2_host_bridge: RTL

Host-side requester for the `pbkdf2` core. It accepts one job as a 32-bit word stream and assembles the full request (salt length, iteration count, password, salt). It issues the request to the core over the core's `in_valid`/`in_ready` handshake, then takes the 256-bit hash through `out_valid`/`out_ready` and returns it to the host as eight 32-bit words. One job is in flight at a time.

---
 rtl/pbkdf2_pkg.sv | 28 ++
 rtl/pbkdf2_hash_ser.sv | 59 +++++
 rtl/pbkdf2_host_bridge.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pbkdf2_pkg.sv
// Shared definitions for the pbkdf2 host bridge.
//   - default field widths for password, salt and hash
//   - host word width and request/response word counts
//   - bridge state enumeration
package pbkdf2_pkg;

  localparam int WORD_W     = 32;
  localparam int PASS_W_DEF = 512;
  localparam int SALT_W_DEF = 512;
  localparam int HASH_W_DEF = 256;

  // Request frame: salt_len word, iters word, password words, salt words.
  localparam int REQ_WORDS = 2 + PASS_W_DEF / WORD_W + SALT_W_DEF / WORD_W;
  localparam int RSP_WORDS = HASH_W_DEF / WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_SEND
  } bridge_state_e;

  function automatic int req_words(input int pass_w, input int salt_w);
    return 2 + pass_w / WORD_W + salt_w / WORD_W;
  endfunction

endpackage

// File: rtl/pbkdf2_hash_ser.sv
// Hash serializer: captures a HASH_W result in parallel and streams it out
// as 32-bit words, most significant word first.
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_load          capture i_hash and start a new response
//   i_hash          parallel hash value
//   o_valid/o_data  response word and its valid
//   o_last          asserted with the final response word
//   i_ready         host accepts the current word
module pbkdf2_hash_ser
  import pbkdf2_pkg::*;
#(
  parameter int HASH_W = HASH_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [HASH_W-1:0] i_hash,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_data,
  output logic              o_last
);

  localparam int RSP    = HASH_W / WORD_W;
  localparam int BEAT_W = (RSP > 1) ? $clog2(RSP) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RSP - 1);

  logic [HASH_W-1:0] r_hash;
  logic [BEAT_W-1:0] r_beat;
  logic              r_valid;

  // The captured hash shifts left on every accepted beat, so the current
  // word is always the top slice and no output mux is needed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hash  <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_hash  <= i_hash;
      r_beat  <= '0;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_hash <= r_hash << WORD_W;
      if (r_beat == LAST_BEAT) begin
        r_beat  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_hash[HASH_W-1 -: WORD_W];
  assign o_last  = r_valid && (r_beat == LAST_BEAT);

endmodule

// File: rtl/pbkdf2_host_bridge.sv
// Host-side requester for the pbkdf2 core. Collects one job as a stream of
// 32-bit words (salt_len, iters, password, salt), presents it to the core
// over in_valid/in_ready, captures the hash over out_valid/out_ready and
// returns it to the host as HASH_W/32 words, MSW first.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   s_valid_i/s_data_i/s_ready_o  host request word stream
//   core_v_o/core_ready_i         request handshake to the core
//   core_salt_len_o, core_iters_o, core_pass_o, core_salt_o  request fields
//   core_out_valid_i/core_hash_i/core_out_ready_o  core result handshake
//   m_valid_o/m_data_o/m_last_o/m_ready_i          host response stream
//   err_o                         one-cycle pulse when a job has iters==0
//   busy_o                        job in flight (ISSUE, WAIT or SEND)
module pbkdf2_host_bridge
  import pbkdf2_pkg::*;
#(
  parameter int PASS_W = PASS_W_DEF,
  parameter int SALT_W = SALT_W_DEF,
  parameter int HASH_W = HASH_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_valid_i,
  input  logic [WORD_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              core_v_o,
  input  logic              core_ready_i,
  output logic [5:0]        core_salt_len_o,
  output logic [31:0]       core_iters_o,
  output logic [PASS_W-1:0] core_pass_o,
  output logic [SALT_W-1:0] core_salt_o,
  input  logic              core_out_valid_i,
  input  logic [HASH_W-1:0] core_hash_i,
  output logic              core_out_ready_o,
  output logic              m_valid_o,
  output logic [WORD_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              err_o,
  output logic              busy_o
);

  localparam int N      = req_words(PASS_W, SALT_W);
  localparam int CNT_W  = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] SALT_BASE = CNT_W'(2 + PASS_W / WORD_W);

  bridge_state_e     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [5:0]        r_salt_len;
  logic [31:0]       r_iters;
  logic [PASS_W-1:0] r_pass;
  logic [SALT_W-1:0] r_salt;
  logic              r_err;

  logic w_beat;
  logic w_hash_load;
  logic w_last_rsp;

  assign w_beat      = (r_state == ST_LOAD) && s_valid_i;
  assign w_hash_load = (r_state == ST_WAIT) && core_out_valid_i;
  assign w_last_rsp  = m_valid_o && m_last_o && m_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_salt_len <= '0;
      r_iters    <= '0;
      r_pass     <= '0;
      r_salt     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_LOAD;
        ST_LOAD: begin
          if (w_beat) begin
            // Password and salt words shift in from the bottom, so the
            // first word of each field ends up in its top slice.
            if (r_cnt == '0)
              r_salt_len <= s_data_i[5:0];
            else if (r_cnt == CNT_W'(1))
              r_iters <= s_data_i;
            else if (r_cnt < SALT_BASE)
              r_pass <= PASS_W'({r_pass, s_data_i});
            else
              r_salt <= SALT_W'({r_salt, s_data_i});

            if (r_cnt == LAST_IDX) begin
              r_cnt <= '0;
              // iters was captured at word 1, long before the final beat.
              if (r_iters == '0)
                r_err <= 1'b1;
              else
                r_state <= ST_ISSUE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_ISSUE: if (core_ready_i) r_state <= ST_WAIT;
        ST_WAIT:  if (core_out_valid_i) r_state <= ST_SEND;
        ST_SEND:  if (w_last_rsp) r_state <= ST_LOAD;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  pbkdf2_hash_ser #(
    .HASH_W (HASH_W)
  ) u_ser (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_load  (w_hash_load),
    .i_hash  (core_hash_i),
    .i_ready (m_ready_i),
    .o_valid (m_valid_o),
    .o_data  (m_data_o),
    .o_last  (m_last_o)
  );

  // Handshake outputs are decoded from the state register only.
  assign s_ready_o        = (r_state == ST_LOAD);
  assign core_v_o         = (r_state == ST_ISSUE);
  assign core_out_ready_o = (r_state == ST_WAIT);
  assign busy_o           = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                            (r_state == ST_SEND);
  assign err_o            = r_err;

  assign core_salt_len_o = r_salt_len;
  assign core_iters_o    = r_iters;
  assign core_pass_o     = r_pass;
  assign core_salt_o     = r_salt;

endmodule
